// File: rtl/mux_xor_event_counter.sv
// rtl/mux_xor_event_counter.sv - per-channel mux/invert flop with edge/level event counter, sticky and overflow flags
module mux_xor_event_counter #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         a,
    input  logic [CHANNELS-1:0]         b,
    input  logic [CHANNELS-1:0]         sel,
    input  logic [CHANNELS-1:0]         inv,
    input  logic [1:0]                  mode,
    input  logic                        hold,
    input  logic                        clear,
    output logic [CHANNELS-1:0]         sig_q,
    output logic [CHANNELS*CNT_W-1:0]   count,
    output logic [CHANNELS-1:0]         sticky,
    output logic [CHANNELS-1:0]         ovf
);

    logic [CHANNELS-1:0] x_d;
    logic [CHANNELS-1:0] sig_qq;
    logic [CHANNELS-1:0] prev_q;

    assign x_d   = ((sel & b) | (~sel & a)) ^ inv;
    assign sig_q = sig_qq;

    // clear deliberately leaves sig/prev alone so an edge straddling it is still seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_qq <= '0;
            prev_q <= '0;
        end else begin
            sig_qq <= x_d;
            prev_q <= sig_qq;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             evt;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             sticky_q, sticky_d;
        logic             ovf_q, ovf_d;

        always_comb begin
            evt = 1'b0;
            case (mode)
                2'd0: evt = sig_qq[i] & ~prev_q[i];
                2'd1: evt = ~sig_qq[i] & prev_q[i];
                2'd2: evt = sig_qq[i] ^ prev_q[i];
                2'd3: evt = sig_qq[i];
                default: evt = 1'b0;
            endcase
        end

        always_comb begin
            cnt_d    = cnt_q;
            sticky_d = sticky_q;
            ovf_d    = ovf_q;
            if (clear) begin
                cnt_d    = '0;
                sticky_d = 1'b0;
                ovf_d    = 1'b0;
            end else if (evt) begin
                sticky_d = 1'b1;
                if (!hold) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q    <= '0;
                sticky_q <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                sticky_q <= sticky_d;
                ovf_q    <= ovf_d;
            end
        end

        assign count[i*CNT_W +: CNT_W] = cnt_q;
        assign sticky[i]               = sticky_q;
        assign ovf[i]                  = ovf_q;
    end

endmodule

// File: tb/tb_mux_xor_event_counter.sv
// tb/tb_mux_xor_event_counter.sv - directed and randomized checks of mux_xor_event_counter against a behavioural model
module tb_mux_xor_event_counter;

    localparam int CH = 2;
    localparam int W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     a, b, sel, inv;
    logic [1:0]        mode;
    logic              hold, clear;
    logic [CH-1:0]     sig_q;
    logic [CH*W-1:0]   count;
    logic [CH-1:0]     sticky, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    int m_sig[CH];
    int m_prev[CH];
    int m_cnt[CH];
    int m_sticky[CH];
    int m_ovf[CH];

    always #5 clk = ~clk;

    mux_xor_event_counter #(.CHANNELS(CH), .CNT_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .sel    (sel),
        .inv    (inv),
        .mode   (mode),
        .hold   (hold),
        .clear  (clear),
        .sig_q  (sig_q),
        .count  (count),
        .sticky (sticky),
        .ovf    (ovf)
    );

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_sig[c] = 0; m_prev[c] = 0; m_cnt[c] = 0; m_sticky[c] = 0; m_ovf[c] = 0;
        end
    endtask

    // One clock edge of the reference: events judged on the value pair seen so far, then the pipeline shifts
    task automatic m_edge(input logic [CH-1:0] ai, bi, si, ii, input logic [1:0] md, input logic hd, cl);
        for (int c = 0; c < CH; c++) begin
            int x;
            bit ev;
            x = ((si[c] ? int'(bi[c]) : int'(ai[c])) + int'(ii[c])) % 2;
            case (md)
                2'd0: ev = (m_prev[c] == 0 && m_sig[c] == 1);
                2'd1: ev = (m_prev[c] == 1 && m_sig[c] == 0);
                2'd2: ev = (m_prev[c] != m_sig[c]);
                default: ev = (m_sig[c] == 1);
            endcase
            if (cl) begin
                m_cnt[c] = 0; m_sticky[c] = 0; m_ovf[c] = 0;
            end else if (ev) begin
                m_sticky[c] = 1;
                if (!hd) begin
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << W);
                    if (m_cnt[c] == 0) m_ovf[c] = 1;
                end
            end
            m_prev[c] = m_sig[c];
            m_sig[c]  = x;
        end
    endtask

    task automatic check(input string tag);
        logic [CH-1:0]   es, est, eo;
        logic [CH*W-1:0] ec;
        for (int c = 0; c < CH; c++) begin
            es[c]          = (m_sig[c] != 0);
            est[c]         = (m_sticky[c] != 0);
            eo[c]          = (m_ovf[c] != 0);
            ec[c*W +: W]   = W'(m_cnt[c]);
        end
        n_cmp++;
        assert (sig_q === es) else begin
            n_bad++; $error("FAIL %s sig_q observed=%b expected=%b", tag, sig_q, es);
        end
        n_cmp++;
        assert (count === ec) else begin
            n_bad++; $error("FAIL %s count observed=%h expected=%h", tag, count, ec);
        end
        n_cmp++;
        assert (sticky === est) else begin
            n_bad++; $error("FAIL %s sticky observed=%b expected=%b", tag, sticky, est);
        end
        n_cmp++;
        assert (ovf === eo) else begin
            n_bad++; $error("FAIL %s ovf observed=%b expected=%b", tag, ovf, eo);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [CH-1:0] ai, bi, si, ii, input logic [1:0] md,
                        input logic hd, cl, input string tag);
        a = ai; b = bi; sel = si; inv = ii; mode = md; hold = hd; clear = cl;
        @(posedge clk);
        m_edge(ai, bi, si, ii, md, hd, cl);
        #1;
        check(tag);
    endtask

    // Two quiet edges flush sig/prev to 0, then a clear zeroes the counters
    task automatic prep(input logic [1:0] md);
        step(2'b00, 2'b00, 2'b00, 2'b00, md, 1'b0, 1'b0, "prep");
        step(2'b00, 2'b00, 2'b00, 2'b00, md, 1'b0, 1'b0, "prep");
        step(2'b00, 2'b00, 2'b00, 2'b00, md, 1'b0, 1'b1, "prep_clr");
    endtask

    initial begin
        logic [0:5] pat;
        int         exp_mode[4];
        exp_mode = '{2, 2, 4, 3};
        pat      = 6'b011010;

        reset = 1'b1; a = 2'b11; b = 2'b00; sel = 2'b00; inv = 2'b00;
        mode = 2'd0; hold = 1'b0; clear = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("in_reset");
        chk("in_reset_count", 32'(count), 32'h0);
        reset = 1'b0;

        step(2'b11, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, "first_e1");
        chk("first_e1_sig", 32'(sig_q), 32'h3);
        step(2'b11, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, "first_e2");
        chk("first_e2_count", 32'(count), 32'h11);
        chk("first_e2_sticky", 32'(sticky), 32'h3);

        // mux/invert path: x[0] goes 0,1,0,1 via sel then inv
        prep(2'd2);
        step(2'b00, 2'b01, 2'b01, 2'b00, 2'd2, 1'b0, 1'b0, "mux_sel");
        step(2'b00, 2'b01, 2'b01, 2'b01, 2'd2, 1'b0, 1'b0, "mux_inv");
        step(2'b00, 2'b01, 2'b00, 2'b01, 2'd2, 1'b0, 1'b0, "mux_a_inv");
        chk("mux_sig0", 32'(sig_q[0]), 32'h1);
        step(2'b00, 2'b01, 2'b00, 2'b01, 2'd2, 1'b0, 1'b0, "mux_flush");
        step(2'b00, 2'b01, 2'b00, 2'b01, 2'd2, 1'b0, 1'b0, "mux_flush");
        chk("mux_count", 32'(count[W-1:0]), 32'd3);

        for (int m = 0; m < 4; m++) begin
            prep(2'(m));
            for (int k = 0; k < 6; k++)
                step({1'b0, pat[k]}, 2'b00, 2'b00, 2'b00, 2'(m), 1'b0, 1'b0, "mode_pat");
            step(2'b00, 2'b00, 2'b00, 2'b00, 2'(m), 1'b0, 1'b0, "mode_flush");
            step(2'b00, 2'b00, 2'b00, 2'b00, 2'(m), 1'b0, 1'b0, "mode_flush");
            chk($sformatf("mode%0d_count", m), 32'(count[W-1:0]), 32'(exp_mode[m]));
        end

        prep(2'd3);
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, "wrap_e0");
        for (int k = 1; k <= 16; k++) begin
            step(2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, "wrap");
            chk("wrap_count", 32'(count[W-1:0]), 32'(k % 16));
            chk("wrap_ovf0", 32'(ovf[0]), (k == 16) ? 32'h1 : 32'h0);
        end
        chk("wrap_ch1_count", 32'(count[2*W-1:W]), 32'h0);
        chk("wrap_ch1_ovf", 32'(ovf[1]), 32'h0);

        prep(2'd0);
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, "hold_pre");
        step(2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, "hold_pre");
        for (int k = 0; k < 6; k++)
            step({1'b0, 1'(k % 2 == 0)}, 2'b00, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, "hold");
        step(2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, "hold_flush");
        chk("hold_count", 32'(count[W-1:0]), 32'd1);
        chk("hold_sticky", 32'(sticky), 32'h1);

        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, "clr_pre");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, "clr_evt");
        chk("clr_count", 32'(count), 32'h0);
        chk("clr_flags", 32'({sticky, ovf}), 32'h0);

        prep(2'd3);
        for (int k = 0; k < 6; k++)
            step(2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, "rst_pre");
        chk("rst_pre_count", 32'(count[W-1:0]), 32'd5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_reset();
        check("async_rst");
        chk("async_rst_all", 32'({sig_q, count, sticky, ovf}), 32'h0);
        reset = 1'b0;
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, "post_rst");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, "post_rst");

        begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
                step(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), md,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
